// File: rtl/muldiv_unit_pkg.sv
// Shared ALU-control opcodes and datapath width used by the multiply/divide
// unit and its HI/LO register file.
package muldiv_unit_pkg;

  localparam int MD_DATA_W          = 32;
  localparam int ALU_CONTROL_LENGTH = 5;

  typedef logic [ALU_CONTROL_LENGTH-1:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD   = 5'd0;
  localparam alu_ctrl_t ALU_SUB   = 5'd1;
  localparam alu_ctrl_t ALU_MULT  = 5'd16;
  localparam alu_ctrl_t ALU_MULTU = 5'd17;
  localparam alu_ctrl_t ALU_DIVU  = 5'd18;
  localparam alu_ctrl_t ALU_MFHI  = 5'd19;
  localparam alu_ctrl_t ALU_MFLO  = 5'd20;
  localparam alu_ctrl_t ALU_MTHI  = 5'd21;
  localparam alu_ctrl_t ALU_MTLO  = 5'd22;

endpackage

// File: rtl/muldiv_unit_hilo.sv
// Architectural HI/LO registers: iterative-result and MTHI/MTLO write muxing
// plus the MFHI/MFLO read select.
module hilo_regs
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mt_hi_we,
  input  logic                          mt_lo_we,
  input  logic [DATA_W-1:0]             mt_data,
  input  logic                          res_we,
  input  logic [DATA_W-1:0]             res_hi,
  input  logic [DATA_W-1:0]             res_lo,
  input  logic [ALU_CONTROL_LENGTH-1:0] alu_control,
  output logic [DATA_W-1:0]             hi,
  output logic [DATA_W-1:0]             lo,
  output logic [DATA_W-1:0]             mf_data
);

  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic [DATA_W-1:0] mf_data_s;

  // HI/LO storage; an iterative result always wins over a move-to write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= {DATA_W{1'b0}};
      lo_r <= {DATA_W{1'b0}};
    end else if (res_we) begin
      hi_r <= res_hi;
      lo_r <= res_lo;
    end else begin
      if (mt_hi_we) hi_r <= mt_data;
      if (mt_lo_we) lo_r <= mt_data;
    end
  end

  // Move-from read select
  always_comb begin
    mf_data_s = {DATA_W{1'b0}};
    case (alu_control)
      ALU_MFHI: mf_data_s = hi_r;
      ALU_MFLO: mf_data_s = lo_r;
      default:  mf_data_s = {DATA_W{1'b0}};
    endcase
  end

  assign hi      = hi_r;
  assign lo      = lo_r;
  assign mf_data = mf_data_s;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring subtract-shift
// step per cycle, result committed to HI/LO in a single finish cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W,
  parameter int ITER   = DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ALU_CONTROL_LENGTH-1:0] alu_control,
  input  logic                          valid,
  input  logic [DATA_W-1:0]             src_a,
  input  logic [DATA_W-1:0]             src_b,
  output logic                          busy,
  output logic                          done,
  output logic                          div_by_zero,
  output logic [DATA_W-1:0]             mf_data,
  output logic [DATA_W-1:0]             hi,
  output logic [DATA_W-1:0]             lo
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [DATA_W-1:0]   ONE_W  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [2*DATA_W-1:0] ONE_2W = {{(2*DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*DATA_W-1:0] acc_r;
  logic [DATA_W-1:0]   opnd_r;
  logic                neg_r;
  logic                dbz_r;

  logic                last_s;
  logic [DATA_W:0]     mul_sum_s;
  logic [2*DATA_W-1:0] mul_step_s;
  logic [DATA_W:0]     div_top_s;
  logic [DATA_W:0]     div_diff_s;
  logic [2*DATA_W-1:0] div_step_s;
  logic [2*DATA_W-1:0] res_s;
  logic                busy_s, done_s, dbz_s;
  logic                mt_hi_we_s, mt_lo_we_s;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1]) mag = ~v + ONE_W;
    else             mag = v;
  endfunction

  assign last_s = (cnt_r == CNT_W'(ITER - 1));

  // One iteration step of each algorithm; acc holds {partial, shifting operand}
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*DATA_W-1:DATA_W]} +
                 (acc_r[0] ? {1'b0, opnd_r} : {(DATA_W+1){1'b0}});
    mul_step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
    div_top_s  = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
    div_diff_s = div_top_s - {1'b0, opnd_r};
    if (!div_diff_s[DATA_W]) begin
      div_step_s = {div_diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
    end else begin
      div_step_s = {div_top_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
    end
    // A zero divisor never borrows, so it naturally yields all-ones / dividend
    if (neg_r) res_s = ~acc_r + ONE_2W;
    else       res_s = acc_r;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (valid) begin
          case (alu_control)
            ALU_MULT, ALU_MULTU: state_s = S_MUL;
            ALU_DIVU:            state_s = S_DIV;
            default:             state_s = S_IDLE;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL:   state_s = last_s ? S_FIN : S_MUL;
      S_DIV:   state_s = last_s ? S_FIN : S_DIV;
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_s = (state_r != S_IDLE);
    done_s = (state_r == S_FIN);
    if (state_r == S_FIN) dbz_s = dbz_r;
    else                  dbz_s = 1'b0;
  end

  // Operand latch on accept and per-cycle iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      acc_r  <= {(2*DATA_W){1'b0}};
      opnd_r <= {DATA_W{1'b0}};
      neg_r  <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (valid) begin
            case (alu_control)
              ALU_MULT: begin
                acc_r  <= {{DATA_W{1'b0}}, mag(src_b)};
                opnd_r <= mag(src_a);
                neg_r  <= src_a[DATA_W-1] ^ src_b[DATA_W-1];
                dbz_r  <= 1'b0;
              end
              ALU_MULTU: begin
                acc_r  <= {{DATA_W{1'b0}}, src_b};
                opnd_r <= src_a;
                neg_r  <= 1'b0;
                dbz_r  <= 1'b0;
              end
              ALU_DIVU: begin
                acc_r  <= {{DATA_W{1'b0}}, src_a};
                opnd_r <= src_b;
                neg_r  <= 1'b0;
                dbz_r  <= (src_b == {DATA_W{1'b0}});
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_r <= mul_step_s;
          cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end
        S_DIV: begin
          acc_r <= div_step_s;
          cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign mt_hi_we_s = (state_r == S_IDLE) && valid && (alu_control == ALU_MTHI);
  assign mt_lo_we_s = (state_r == S_IDLE) && valid && (alu_control == ALU_MTLO);

  hilo_regs #(.DATA_W(DATA_W)) u_hilo (
    .clk         (clk),
    .rst         (rst),
    .mt_hi_we    (mt_hi_we_s),
    .mt_lo_we    (mt_lo_we_s),
    .mt_data     (src_a),
    .res_we      (done_s),
    .res_hi      (res_s[2*DATA_W-1:DATA_W]),
    .res_lo      (res_s[DATA_W-1:0]),
    .alu_control (alu_control),
    .hi          (hi),
    .lo          (lo),
    .mf_data     (mf_data)
  );

  assign busy        = busy_s;
  assign done        = done_s;
  assign div_by_zero = dbz_s;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  alu_control = ALU_ADD;
  logic        valid = 1'b0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] mf_data, hi, lo;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .alu_control(alu_control), .valid(valid),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .mf_data(mf_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb;
    e.dbz = 1'b0;
    p = 64'd0;
    case (op)
      ALU_MULTU: p = {32'd0, a} * {32'd0, b};
      ALU_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end
      default: p = 64'd0;
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    if (op == ALU_DIVU) begin
      if (b == 32'd0) begin
        e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
      end else begin
        e.hi = a % b; e.lo = a / b;
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse pops one expectation and checks the committed HI/LO
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        mon_e = sb_q.pop_front();
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
        @(posedge clk); #1;
        chk("hi", {32'd0, hi}, {32'd0, mon_e.hi});
        chk("lo", {32'd0, lo}, {32'd0, mon_e.lo});
      end
    end
  end

  task automatic start_iter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    sb_q.push_back(e);
    @(negedge clk);
    alu_control = op; src_a = a; src_b = b; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_iter(input logic [31:0] lat_exp, input bit check_lat, input exp_t e);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 64'(n), 64'(lat_exp));
    else if (check_lat) chk("latency", 64'(n), 64'(lat_exp));
    @(posedge clk); #1;
    mhi = e.hi; mlo = e.lo;
  endtask

  task automatic do_iter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    start_iter(op, a, b, e);
    wait_iter(32'd32, 1'b1, e);
  endtask

  task automatic mt(input logic [4:0] op, input logic [31:0] d);
    @(negedge clk);
    alu_control = op; src_a = d; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    if (op == ALU_MTHI) mhi = d; else mlo = d;
    chk("mt_no_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_mf(input logic [4:0] op, input logic [31:0] exp);
    @(negedge clk);
    alu_control = op; valid = 1'b0;
    #1;
    chk("mf_data", {32'd0, mf_data}, {32'd0, exp});
  endtask

  initial begin
    exp_t e;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          kind;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {62'd0, done, div_by_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    mt(ALU_MTHI, 32'h1234_5678);
    check_mf(ALU_MFHI, 32'h1234_5678);
    mt(ALU_MTLO, 32'h0000_0055);
    check_mf(ALU_MFLO, 32'h0000_0055);
    check_mf(ALU_ADD, 32'd0);

    e = '{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dbz: 1'b0};
    do_iter(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
    e = '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1, dbz: 1'b0};
    do_iter(ALU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, e);
    e = '{hi: 32'h0000_0002, lo: 32'h0000_000E, dbz: 1'b0};
    do_iter(ALU_DIVU, 32'd100, 32'd7, e);
    e = '{hi: 32'h0000_1234, lo: 32'hFFFF_FFFF, dbz: 1'b1};
    do_iter(ALU_DIVU, 32'h0000_1234, 32'd0, e);

    // MTLO while busy must be ignored; MFLO during the op returns the old LO
    e = model(ALU_MULTU, 32'd3, 32'd4);
    start_iter(ALU_MULTU, 32'd3, 32'd4, e);
    alu_control = ALU_MTLO; src_a = 32'h0000_00AA; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("mtlo_while_busy", {32'd0, lo}, {32'd0, mlo});
    alu_control = ALU_MFLO; #1;
    chk("mflo_while_busy", {32'd0, mf_data}, {32'd0, mlo});
    wait_iter(32'd32, 1'b0, e);
    check_mf(ALU_MFLO, 32'd12);

    // Reset abort at iteration 10
    mt(ALU_MTHI, 32'h0000_DEAD);
    @(negedge clk);
    alu_control = ALU_MULTU; src_a = 32'h0001_0001; src_b = 32'h0000_0003; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    mhi = 32'd0; mlo = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e = '{hi: 32'd1, lo: 32'd4, dbz: 1'b0};
    do_iter(ALU_DIVU, 32'd9, 32'd2, e);

    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      b = $urandom;
      case (kind)
        0: op = ALU_MULT;
        1: op = ALU_MULTU;
        2: op = ALU_DIVU;
        3: begin op = ALU_DIVU; b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 300)); end
        default: op = ALU_MTHI;
      endcase
      if (kind == 4) begin
        mt(($urandom_range(0, 1) == 0) ? ALU_MTHI : ALU_MTLO, a);
      end else begin
        do_iter(op, a, b, model(op, a, b));
      end
      check_mf(ALU_MFHI, mhi);
      check_mf(ALU_MFLO, mlo);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
